// File: rtl/led_arbiter.sv
// -----------------------------------------------------------------------------
// led_arbiter
//   Shares the two board LEDs between several on-chip requesters. A fixed
//   priority arbiter (index 0 highest) picks one owner and latches its mode at
//   grant time. A free-running prescaler produces a tick that advances a 3-bit
//   phase counter, and the latched mode turns that phase into a blink pattern.
//   Each grant is held for at least MIN_HOLD_TICKS ticks before it can be
//   preempted or released.
//
// Ports
//   clk    : system clock
//   rst_   : asynchronous active-low reset
//   req    : level request per requester
//   mode   : 2-bit pattern per requester, requester i uses mode[2i+1:2i]
//   grant  : one-hot current owner, zero when idle
//   busy   : high while an owner holds the LEDs
//   led    : registered LED drive, ice_led[1:0]
// -----------------------------------------------------------------------------
module led_arbiter #(
    parameter int REQ_COUNT      = 4,
    parameter int TICK_LOG2      = 20,
    parameter int MIN_HOLD_TICKS = 8
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [REQ_COUNT-1:0]   req,
    input  logic [2*REQ_COUNT-1:0] mode,
    output logic [REQ_COUNT-1:0]   grant,
    output logic                   busy,
    output logic [1:0]             led
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [TICK_LOG2-1:0]   r_presc;
    logic [2:0]             r_phase;
    logic [7:0]             r_hold;
    logic [7:0]             w_hold_next;
    logic [REQ_COUNT-1:0]   r_grant;
    logic [REQ_COUNT-1:0]   w_grant_next;
    logic [1:0]             r_mode;
    logic [1:0]             r_led;
    logic [1:0]             w_pattern;

    logic                   w_tick;
    logic                   w_load;
    logic [REQ_COUNT-1:0]   w_first;
    logic [REQ_COUNT-1:0][1:0] w_mode_masked;
    logic [1:0]             w_first_mode;
    logic                   w_any_req;
    logic                   w_owner_req;
    logic                   w_other_req;
    logic                   w_higher_req;

    assign w_tick = &r_presc;

    // Two's-complement trick isolates the lowest set request bit, which is
    // the highest-priority requester, as a one-hot vector.
    assign w_first = req & ((~req) + REQ_COUNT'(1));

    // Mode of the winning requester: mask every slot by its one-hot select
    // bit, then OR the masked slots together.
    generate
        for (genvar gi = 0; gi < REQ_COUNT; gi++) begin : g_mode_mask
            assign w_mode_masked[gi] = mode[2*gi +: 2] & {2{w_first[gi]}};
        end
    endgenerate

    always_comb begin
        w_first_mode = 2'b00;
        for (int i = 0; i < REQ_COUNT; i++) begin
            w_first_mode = w_first_mode | w_mode_masked[i];
        end
    end

    assign w_any_req    = |req;
    assign w_owner_req  = |(req & r_grant);
    assign w_other_req  = |(req & ~r_grant);
    // With a one-hot grant, grant-1 is the mask of all higher-priority slots.
    assign w_higher_req = |(req & (r_grant - REQ_COUNT'(1)));

    // Next-state / grant decision
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_hold_next  = r_hold;
        w_load       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_load = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    w_hold_next = r_hold + 8'd1;
                    if (r_hold + 8'd1 == 8'(MIN_HOLD_TICKS)) begin
                        w_state_next = ST_OPEN;
                    end
                end
            end
            ST_OPEN: begin
                if (w_higher_req || (!w_owner_req && w_other_req)) begin
                    w_load = 1'b1;
                end else if (!w_owner_req) begin
                    w_grant_next = '0;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_grant_next = '0;
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_grant_next = w_first;
            w_hold_next  = 8'd0;
            w_state_next = ST_HOLD;
        end
    end

    // Pattern from the latched mode and the current phase
    always_comb begin
        w_pattern = 2'b00;
        case (r_mode)
            2'd0:    w_pattern = 2'b11;
            2'd1:    w_pattern = {2{r_phase[2]}};
            2'd2:    w_pattern = {2{r_phase[0]}};
            default: w_pattern = {~r_phase[1], r_phase[1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_phase <= 3'd0;
            r_hold  <= 8'd0;
            r_grant <= '0;
            r_mode  <= 2'b00;
            r_led   <= 2'b00;
        end else begin
            r_state <= w_state_next;
            r_presc <= r_presc + TICK_LOG2'(1);
            r_hold  <= w_hold_next;
            r_grant <= w_grant_next;
            // A grant restarts the pattern even if a tick lands on the same edge.
            if (w_load) begin
                r_phase <= 3'd0;
                r_mode  <= w_first_mode;
            end else if (w_tick) begin
                r_phase <= r_phase + 3'd1;
            end
            // LED follows the registered owner/mode/phase one cycle later.
            r_led <= (r_grant != '0) ? w_pattern : 2'b00;
        end
    end

    assign grant = r_grant;
    assign busy  = (r_state != ST_IDLE);
    assign led   = r_led;

endmodule

// File: tb/tb_led_arbiter.sv
module tb_led_arbiter;

    localparam int REQ_N = 4;
    localparam int TL    = 2;
    localparam int TICKP = 1 << TL;
    localparam int MINH  = 2;

    logic              clk;
    logic              rst_;
    logic [REQ_N-1:0]  req;
    logic [2*REQ_N-1:0] mode;
    logic [REQ_N-1:0]  grant;
    logic              busy;
    logic [1:0]        led;

    int n_total;
    int n_bad;

    // Reference model state: owner index (-1 = nobody), latched mode,
    // phase 0..7, ticks held so far, hold-window flag, edge count since reset.
    int m_owner;
    int m_mode;
    int m_phase;
    int m_hold;
    bit m_in_hold;
    int m_cyc;
    int m_led;

    led_arbiter #(
        .REQ_COUNT     (REQ_N),
        .TICK_LOG2     (TL),
        .MIN_HOLD_TICKS(MINH)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .req  (req),
        .mode (mode),
        .grant(grant),
        .busy (busy),
        .led  (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pattern_of(input int md, input int ph);
        case (md)
            0:       return 3;
            1:       return (ph >= 4) ? 3 : 0;
            2:       return (ph % 2 == 1) ? 3 : 0;
            default: return ((ph / 2) % 2 == 1) ? 1 : 2;
        endcase
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_mode    = 0;
        m_phase   = 0;
        m_hold    = 0;
        m_in_hold = 0;
        m_cyc     = 0;
        m_led     = 0;
    endtask

    // Advance the reference by one clock edge using the inputs seen at that edge.
    task automatic model_step(input logic [REQ_N-1:0] r, input logic [2*REQ_N-1:0] md);
        int lowest;
        bit tick;
        bit take;
        int new_led;
        tick    = (m_cyc % TICKP) == (TICKP - 1);
        new_led = (m_owner >= 0) ? pattern_of(m_mode, m_phase) : 0;
        lowest  = -1;
        for (int i = REQ_N - 1; i >= 0; i--) if (r[i]) lowest = i;
        take = 0;
        if (m_owner < 0) begin
            if (lowest >= 0) take = 1;
        end else if (m_in_hold) begin
            if (tick) begin
                m_hold++;
                if (m_hold == MINH) m_in_hold = 0;
            end
        end else begin
            if (lowest >= 0 && lowest < m_owner) take = 1;
            else if (!r[m_owner]) begin
                if (lowest >= 0) take = 1;
                else m_owner = -1;
            end
        end
        if (take) begin
            m_owner   = lowest;
            m_mode    = int'((md >> (2 * lowest)) & 8'h3);
            m_hold    = 0;
            m_in_hold = 1;
            m_phase   = 0;
        end else if (tick) begin
            m_phase = (m_phase + 1) % 8;
        end
        m_led = new_led;
        m_cyc++;
    endtask

    function automatic logic [31:0] exp_grant();
        return (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    endfunction

    // One clock: apply inputs, step model at the edge, compare 1 time unit later.
    task automatic do_cycle(input logic [REQ_N-1:0] r, input logic [2*REQ_N-1:0] md);
        req  = r;
        mode = md;
        @(posedge clk);
        model_step(r, md);
        #1;
        check_eq("grant", 32'(grant), exp_grant());
        check_eq("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
        check_eq("led", 32'(led), 32'(m_led));
    endtask

    task automatic run(input int n, input logic [REQ_N-1:0] r, input logic [2*REQ_N-1:0] md);
        for (int i = 0; i < n; i++) do_cycle(r, md);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_    = 1'b0;
        req     = '0;
        mode    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_grant", 32'(grant), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_led", 32'(led), 32'd0);
        rst_ = 1'b1;

        // Single request, fast blink
        run(10, 4'b0000, 8'h00);
        do_cycle(4'b0100, 8'h20);
        check_eq("single_grant", 32'(grant), 32'h4);
        run(24, 4'b0100, 8'h20);
        $display("txn single: grant=%b led=%b", grant, led);
        run(20, 4'b0000, 8'h00);

        // Simultaneous requests, then owner drops
        do_cycle(4'b1010, 8'h00);
        check_eq("simul_grant", 32'(grant), 32'h2);
        run(14, 4'b1010, 8'h00);
        do_cycle(4'b1000, 8'h00);
        check_eq("handover_grant", 32'(grant), 32'h8);
        run(20, 4'b1000, 8'h00);
        $display("txn simultaneous: grant=%b led=%b", grant, led);
        run(20, 4'b0000, 8'h00);

        // Hold guarantee on a one-cycle pulse
        do_cycle(4'b0100, 8'h10);
        run(5, 4'b0000, 8'h00);
        check_eq("hold_grant", 32'(grant), 32'h4);
        run(12, 4'b0000, 8'h00);
        check_eq("hold_release", 32'(grant), 32'h0);
        $display("txn hold: grant=%b led=%b", grant, led);

        // Preemption of solid owner 3 by requester 0 in alternate mode
        run(14, 4'b1000, 8'h00);
        check_eq("preempt_solid_led", 32'(led), 32'h3);
        do_cycle(4'b1001, 8'h03);
        check_eq("preempt_grant", 32'(grant), 32'h1);
        do_cycle(4'b1001, 8'h03);
        check_eq("preempt_led_ph0", 32'(led), 32'h2);
        run(12, 4'b1001, 8'h03);
        $display("txn preempt: grant=%b led=%b", grant, led);
        run(20, 4'b0000, 8'h00);

        // Lower priority never preempts
        run(14, 4'b0010, 8'h04);
        run(12, 4'b1010, 8'h04);
        check_eq("nopreempt_grant", 32'(grant), 32'h2);
        run(3, 4'b1000, 8'h04);
        $display("txn lowprio: grant=%b led=%b", grant, led);
        run(20, 4'b0000, 8'h00);

        // Asynchronous reset while solid pattern is showing
        run(14, 4'b0001, 8'h00);
        check_eq("prereset_led", 32'(led), 32'h3);
        rst_ = 1'b0;
        #2;
        check_eq("async_led", 32'(led), 32'h0);
        check_eq("async_grant", 32'(grant), 32'h0);
        check_eq("async_busy", 32'(busy), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        model_reset();
        do_cycle(4'b0001, 8'h00);
        check_eq("regrant_after_reset", 32'(grant), 32'h1);
        $display("txn reset: grant=%b led=%b", grant, led);
        run(10, 4'b0001, 8'h00);

        // Randomized traffic; mode jitters every cycle to exercise the latch
        begin
            logic [REQ_N-1:0]   r_rand;
            logic [2*REQ_N-1:0] m_rand;
            r_rand = '0;
            for (int i = 0; i < 2500; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    r_rand = REQ_N'($urandom_range(0, (1 << REQ_N) - 1));
                    $display("txn rand %0d: req=%b", i, r_rand);
                end
                m_rand = (2 * REQ_N)'($urandom);
                do_cycle(r_rand, m_rand);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
